// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter with hold limit driving a shared 4:1 bit mux.
module rr_mux_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] in,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       busy,
    output logic       q
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t           state;
    logic [1:0]       last;
    logic [1:0]       nxt;
    logic [3:0]       others;
    logic [CNT_W-1:0] hold_cnt;
    logic             rotate;
    logic             release_path;
    logic             hold_full;

    // first set bit scanning last+1, last+2, last+3, last
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] c;
        pick = l;
        for (int k = 4; k >= 1; k--) begin
            c = l + 2'(k);
            if (r[c]) pick = c;
        end
    endfunction

    // grant is zero when idle, so others covers both the idle and the holding case
    assign others       = req & ~grant;
    assign nxt          = pick(others, last);
    assign hold_full    = hold_cnt == CNT_W'(MAX_HOLD);
    assign rotate       = (state == IDLE) ? |req : (|others && (!req[sel] || hold_full));
    assign release_path = state == GRANT && !req[sel] && !(|others);
    assign q            = busy & in[sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 2'b00;
            grant    <= 4'b0000;
            busy     <= 1'b0;
            hold_cnt <= '0;
            last     <= 2'd3;
        end else if (rotate) begin
            state    <= GRANT;
            sel      <= nxt;
            grant    <= 4'b0001 << nxt;
            busy     <= 1'b1;
            hold_cnt <= CNT_W'(1);
            last     <= nxt;
        end else if (release_path) begin
            state    <= IDLE;
            grant    <= 4'b0000;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else if (state == GRANT && !hold_full) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: scoreboard bench; a behavioural arbiter model queues the expected outputs per edge.
module tb_rr_mux_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] in  = 4'b0000;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       q;

    int errors = 0;
    int checks = 0;
    logic [6:0] sb[$];

    int m_busy, m_sel, m_last, m_cnt;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .req(req), .in(in),
        .sel(sel), .grant(grant), .busy(busy), .q(q)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_from(input logic [3:0] r, input int l);
        for (int k = 1; k <= 4; k++)
            if (r[(l + k) % 4]) return (l + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_sel = 0; m_last = 3; m_cnt = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] oth;
        int w;
        if (m_busy == 0) begin
            if (r != 0) begin
                w = next_from(r, m_last);
                m_sel = w; m_last = w; m_busy = 1; m_cnt = 1;
            end
        end else begin
            oth = r;
            oth[m_sel] = 1'b0;
            if (!r[m_sel]) begin
                if (oth != 0) begin
                    w = next_from(oth, m_last);
                    m_sel = w; m_last = w; m_cnt = 1;
                end else begin
                    m_busy = 0; m_cnt = 0;
                end
            end else if (m_cnt == 4 && oth != 0) begin
                w = next_from(oth, m_last);
                m_sel = w; m_last = w; m_cnt = 1;
            end else if (m_cnt < 4) begin
                m_cnt++;
            end
        end
    endtask

    // drive req for one edge, queue the model prediction, then compare after the edge
    task automatic drive(input logic [3:0] r);
        logic [6:0] e;
        logic [3:0] g;
        req = r;
        model_step(r);
        g = m_busy ? (4'b0001 << m_sel) : 4'b0000;
        sb.push_back({2'(m_sel), g, m_busy[0]});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("grant", 32'(grant), 32'(e[4:1]));
        chk("busy", 32'(busy), 32'(e[0]));
        if (e[0]) chk("sel", 32'(sel), 32'(e[6:5]));
        chk("q", 32'(q), 32'(e[0] & in[e[6:5]]));
    endtask

    // asynchronous reset applied between edges; outputs must clear without a clock
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        in = 4'b0100;
        repeat (3) drive(4'b0100);
        chk("t1_grant", 32'(grant), 32'h4);
        chk("t1_q", 32'(q), 32'h1);
        drive(4'b0000);
        chk("t1_release", 32'(busy), 32'h0);

        do_reset();
        in = 4'b1010;
        repeat (21) drive(4'b1111);

        do_reset();
        repeat (10) drive(4'b0010);
        chk("t3_hold_sat", 32'(dut.hold_cnt), 32'h4);
        chk("t3_grant", 32'(grant), 32'h2);

        do_reset();
        in = 4'b0101;
        drive(4'b1000);
        chk("t4_g3", 32'(grant), 32'h8);
        drive(4'b0101);
        chk("t4_wrap", 32'(grant), 32'h1);
        drive(4'b0100);
        chk("t4_next", 32'(grant), 32'h4);

        do_reset();
        in = 4'b0100;
        drive(4'b0100);
        drive(4'b0100);
        chk("t5_pre_busy", 32'(q), 32'h1);
        do_reset();
        drive(4'b1010);
        chk("t5_first", 32'(grant), 32'h2);

        in = 4'b0010;
        #1;
        chk("t6_q_hi", 32'(q), 32'h1);
        in = 4'b0000;
        #1;
        chk("t6_q_lo", 32'(q), 32'h0);
        chk("t6_sel", 32'(sel), 32'h1);

        for (int i = 0; i < 20; i++) begin
            in = 4'($urandom);
            drive(4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 bit-select datapath among four requesters.
- Each requester raises req[i]; the block picks a winner, drives sel/grant and forwards in[sel] to q.
- A hold limit lets a granted requester keep the path for up to MAX_HOLD consecutive cycles while others wait.
- Sits directly in front of the 4:1 mux; sel is the mux select, q is the mux output gated by busy.

Parameters:
MAX_HOLD, 4, max consecutive cycles one requester keeps the grant while another req is pending; legal range 1..7; 1 = strict per-cycle rotation
CNT_W, 3, width of hold counter; must hold MAX_HOLD

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
req  input  4  request per requester, level-sensitive
in  input  4  data bit per requester (mux data inputs)
sel  output  2  registered index of granted requester (mux select)
grant  output  4  registered one-hot grant; all zero when idle
busy  output  1  registered; 1 while any grant is active
q  output  1  combinational in[sel] AND busy

Behaviour:
- One clock (clk); rst asynchronous, active-high; all state is in flops cleared by rst.
- Reset values: state=IDLE, sel=2'b00, grant=4'b0000, busy=0, q=0, hold_cnt=0, last=2'd3 (so requester 0 has top priority after reset).
- Rotation order from last: (last+1), (last+2), (last+3), last, all mod 4. The first asserted req in that order wins.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, at the next edge, grant the winner: sel=winner, grant=onehot(winner), busy=1, hold_cnt=1, last=winner, go to GRANT.
  - Latency is exactly 1 clk from req sampled to grant visible.
- GRANT, evaluated each edge, first match wins:
  1. req[sel]==0 and another req is set: switch to the next winner in rotation at the same edge (no idle gap). hold_cnt=1, last=new.
  2. req[sel]==0 and no other req is set: go to IDLE. grant=0, busy=0. sel keeps its value and last is unchanged.
  3. req[sel]==1, hold_cnt==MAX_HOLD and another req is set: rotate to the next winner, excluding the current holder. hold_cnt=1.
  4. req[sel]==1, otherwise: keep the grant. hold_cnt increments, saturating at MAX_HOLD.
- Other requests never preempt before hold expires.
- q tracks in[sel] combinationally while busy=1; a change on in during a grant appears on q in the same cycle. q=0 whenever busy=0.
- grant is always one-hot or zero; grant[sel]==busy.
- Simultaneous release plus new req: handled by rule 1; the released requester is ranked last.
- rst asserted mid-grant: outputs go to reset values immediately, without waiting for clk. After rst deasserts, arbitration restarts from requester 0 priority.
- req toggling between edges is ignored; only values at the clk edge matter.

Test Plan:
1. Reset, then req=4'b0100 for 3 cycles, in=4'b0100 -> 1 cycle later grant=4'b0100, sel=2, busy=1, q=1. Release req -> next edge grant=0, busy=0, q=0.
2. req=4'b1111 held, MAX_HOLD=4 -> grant to 0 for 4 cycles, then 1, 2, 3, 0; each holds exactly 4 cycles; no idle cycle between grants.
3. Requester 1 granted, holds while req=4'b0010 alone for 10 cycles -> grant stays 4'b0010; hold_cnt saturates at 4; no rotation.
4. Granted requester 3 drops req while req0 and req2 are set -> same edge grants 0 (wrap-around from last=3); next release of 0 grants 2.
5. Mid-grant (sel=2, busy=1), assert rst between clock edges -> grant, busy, q go to 0 immediately. Release rst with req=4'b1010 -> first grant to requester 1.
6. During grant to requester 1, toggle in=4'b0010 then 4'b0000 -> q follows 1 then 0 within the same cycle; sel unchanged.
